// File: rtl/output_streamer_pkg.sv
// Shared definitions for the output streamer: default geometry, FSM states and index bit reversal.
package output_streamer_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 16;
  localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Reverses the low 'width' bits of value; bits above width come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) result[i] = value[width-1-i];
    end
    return result;
  endfunction

endpackage

// File: rtl/output_streamer_addr_gen.sv
// Sequence counter and last-word detection for the output streamer.
// OUTPUT_STREAMER_BIT_REVERSE_EN selects bit-reversed source order; undefined gives natural order.
module stream_addr_gen
  import output_streamer_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] src_index,
  output logic              last
);

  logic [ADDR_W-1:0] count;

  // The counter parks on the final value after the last transfer; only a new frame clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance && !last) begin
      count <= count + ADDR_W'(1);
    end
  end

  assign last = (count == ADDR_W'(DEPTH - 1));

`ifdef OUTPUT_STREAMER_BIT_REVERSE_EN
  assign src_index = ADDR_W'(bit_reverse(32'(count), ADDR_W));
`else
  assign src_index = count;
`endif

endmodule

// File: rtl/output_streamer.sv
// Snapshots a parallel frame and streams it out one word per valid/ready handshake.
// OUTPUT_STREAMER_BIT_REVERSE_EN (see stream_addr_gen) switches to bit-reversed word order.
module output_streamer
  import output_streamer_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DEPTH*DATA_W-1:0] frame_in,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [ADDR_W-1:0]       out_index,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] snap [DEPTH];
  logic [ADDR_W-1:0] src_index;
  logic              last;
  logic              accept;
  logic              xfer;

  assign accept = (state == IDLE) && start;
  assign xfer   = (state == STREAM) && out_ready;

  stream_addr_gen #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept),
    .advance   (xfer),
    .src_index (src_index),
    .last      (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture happens only on acceptance, so later frame_in activity cannot leak into a running frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) snap[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < DEPTH; k++) snap[k] <= frame_in[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = STREAM;
      STREAM:  if (out_ready && last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign out_valid = (state == STREAM);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Data-side outputs are forced to zero outside the valid window.
  assign out_data  = out_valid ? snap[src_index] : '0;
  assign out_index = out_valid ? src_index : '0;
  assign out_last  = out_valid && last;

endmodule

// File: doc/output_streamer.md
OUTPUT_STREAMER -- requirements
Module: output_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning words per frame; ADDR_W = log2(DEPTH) = 4.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  frame load request; sampled only in IDLE.
REQ-007 frame_in  input  DEPTH*DATA_W  parallel buffer contents; word k at bits [k*DATA_W +: DATA_W].
REQ-008 out_ready  input  1  downstream accepts the current word.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_data  output  DATA_W  streamed word.
REQ-011 out_index  output  ADDR_W  source index in frame_in of out_data.
REQ-012 out_last  output  1  current word is the final word of the frame.
REQ-013 busy  output  1  frame in progress (state != IDLE).
REQ-014 done  output  1  one-cycle pulse after the final transfer.

Function
REQ-015 States: IDLE, STREAM, DONE.
REQ-016 IDLE: start=1 -> snapshot all DEPTH words of frame_in into internal registers, clear sequence counter, go to STREAM.
REQ-017 out_valid = 1 in the cycle after start is accepted (1-cycle latency), with the first word.
REQ-018 Transfer occurs on the rising edge when out_valid && out_ready; counter increments by 1.
REQ-019 While out_valid && !out_ready: out_data, out_index, out_last held stable; no word dropped or repeated.
REQ-020 out_last = 1 exactly when counter = DEPTH-1.
REQ-021 Transfer with out_last=1 -> DONE; out_valid=0 in DONE.
REQ-022 DONE lasts one cycle with done=1, then IDLE; start during DONE is ignored.
REQ-023 start during STREAM or DONE is ignored; snapshot is not modified; frame_in changes after capture do not affect output.
REQ-024 Counter is ADDR_W bits; wrap from DEPTH-1 to 0 occurs only through IDLE, never inside a frame.
REQ-025 out_ready held 1 continuously -> frame completes in exactly DEPTH cycles after the first valid cycle.
REQ-026 out_data, out_index, out_last are 0 whenever out_valid=0.

Reset
REQ-027 rst_n=0 -> immediately IDLE; out_valid, out_data, out_index, out_last, busy, done = 0; counter = 0; snapshot registers = 0.
REQ-028 Reset mid-frame discards the frame; no done pulse; after release, a new start is required.

Configuration
REQ-029 Macro OUTPUT_STREAMER_BIT_REVERSE_EN defined: source index = bit-reverse of counter over ADDR_W bits (order 0,8,4,12,2,10,...,15); out_index reports the reversed value.
REQ-030 Macro not defined: source index = counter (natural order 0..15); no reversal logic present.
REQ-031 out_last, done, and timing are identical in both builds.

Structure
REQ-032 Shared package output_streamer_pkg SHALL hold DATA_W, DEPTH, ADDR_W defaults, the state enum typedef, and the bit-reverse function.
REQ-033 One sub-module stream_addr_gen SHALL contain the sequence counter, last detection, and optional bit reversal.

Verification
REQ-034 frame_in word k = 0xA000_0000+k, start pulse, out_ready=1 -> 16 consecutive valid cycles, out_data 0xA0000000..0xA000000F (natural build), out_last on the 16th, done one cycle later.
REQ-035 Same frame, BIT_REVERSE_EN build -> out_index sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; out_data matches index.
REQ-036 out_ready toggling 1,0,0,1 -> out_data stable across stalls; 16 distinct transfers total; done after the 16th.
REQ-037 frame_in changed to all 0xFFFFFFFF and start re-pulsed after word 3 -> stream continues with original values, second start ignored, busy stays 1.
REQ-038 rst_n asserted after word 7 -> all outputs 0 asynchronously, no done; new start after release -> full frame from index 0.
